// File: rtl/v810_bus_pkg.sv
// Shared types for the V810 fetch/data memory arbiter: FSM states, grant codes, bus widths.
package v810_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } bus_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/v810_bus_arb_if.sv
// Fetch port, data port and external memory bus of the V810 arbiter.
interface v810_bus_arb_if;
  import v810_bus_pkg::*;

  logic [ADDR_W-1:0] IA;
  logic [DATA_W-1:0] ID;
  logic              IREQ;
  logic              IACK;

  logic [ADDR_W-1:0] DA;
  logic [DATA_W-1:0] DD_I;
  logic [DATA_W-1:0] DD_O;
  logic [BE_W-1:0]   DBE;
  logic              DWR;
  logic              DREQ;
  logic              DACK;

  logic [ADDR_W-1:0] MA;
  logic [DATA_W-1:0] MD_I;
  logic [DATA_W-1:0] MD_O;
  logic [BE_W-1:0]   MBE;
  logic              MWR;
  logic              MREQ;
  logic              MACK;

  logic [1:0]        GNT;

  // Arbiter side.
  modport slave (
    input  IA, IREQ, DA, DD_O, DBE, DWR, DREQ, MD_I, MACK,
    output ID, IACK, DD_I, DACK, MA, MD_O, MBE, MWR, MREQ, GNT
  );

  // Core and memory side.
  modport master (
    output IA, IREQ, DA, DD_O, DBE, DWR, DREQ, MD_I, MACK,
    input  ID, IACK, DD_I, DACK, MA, MD_O, MBE, MWR, MREQ, GNT
  );

endinterface

// File: rtl/v810_bus_arb.sv
// Merges the V810 fetch and data ports onto one memory bus. Data has priority,
// bounded by a streak counter so a pending fetch always makes progress.
module v810_bus_arb
  import v810_bus_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input logic           CLK,
  input logic           RESn,
  input logic           CE,
  v810_bus_arb_if.slave bus
);

  localparam int unsigned CNT_W = (MAX_DSTREAK > 0) ? $clog2(MAX_DSTREAK + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DSTREAK);

  bus_state_t       state_q, state_d;
  logic [CNT_W-1:0] dstreak_q, dstreak_d;
  logic [1:0]       gnt;
  logic             data_win;
  logic             iack;
  logic             dack;

  assign bus.ID   = bus.MD_I;
  assign bus.DD_I = bus.MD_I;
  assign bus.MD_O = bus.DD_O;

  always_ff @(posedge CLK) begin
    if (!RESn) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
    end
  end

  // Owner selection, bus routing, lock transitions and streak update.
  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    gnt       = GNT_NONE;
    bus.MA    = '0;
    bus.MBE   = '0;
    bus.MWR   = 1'b0;

    data_win = bus.DREQ && (!bus.IREQ || (MAX_DSTREAK == 0) || (dstreak_q < CNT_MAX));

    // Reset masks the owner so every bus output drops while RESn is low.
    if (RESn) begin
      case (state_q)
        LOCK_I:  gnt = GNT_I;
        LOCK_D:  gnt = GNT_D;
        default: begin
          if (data_win) begin
            gnt = GNT_D;
          end else if (bus.IREQ) begin
            gnt = GNT_I;
          end
        end
      endcase
    end

    case (gnt)
      GNT_I: begin
        bus.MA  = bus.IA;
        bus.MBE = '1;
      end
      GNT_D: begin
        bus.MA  = bus.DA;
        bus.MBE = bus.DBE;
        bus.MWR = bus.DWR;
      end
      default: ;
    endcase

    iack     = bus.MACK && (gnt == GNT_I);
    dack     = bus.MACK && (gnt == GNT_D);
    bus.MREQ = (gnt != GNT_NONE);
    bus.GNT  = gnt;
    bus.IACK = iack;
    bus.DACK = dack;

    if (CE) begin
      case (state_q)
        IDLE: begin
          if ((gnt == GNT_I) && !bus.MACK) begin
            state_d = LOCK_I;
          end else if ((gnt == GNT_D) && !bus.MACK) begin
            state_d = LOCK_D;
          end
        end
        LOCK_I, LOCK_D: begin
          if (bus.MACK) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (!bus.IREQ || iack) begin
        dstreak_d = '0;
      end else if (dack && (dstreak_q < CNT_MAX)) begin
        dstreak_d = dstreak_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_v810_bus_arb.sv
// Bench for v810_bus_arb: queued requesters, wait-state memory model and an
// expected-completion scoreboard, against MAX_DSTREAK=4 and MAX_DSTREAK=0 instances.
module tb_v810_bus_arb;
  import v810_bus_pkg::*;

  localparam logic [31:0] RD_XOR = 32'hC0DE_0000;

  typedef struct {
    logic [1:0]  port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        wr;
  } acc_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ce;
  logic use0;

  logic        ireq, dreq, dwr;
  logic [31:0] ia, da, dd_o;
  logic [3:0]  dbe;

  int unsigned waits = 0;
  int unsigned wc4 = 0;
  int unsigned wc0 = 0;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] fq[$];
  acc_t        dq[$];
  acc_t        exp_q[$];

  always #5 clk = ~clk;

  v810_bus_arb_if bus4();
  v810_bus_arb_if bus0();

  v810_bus_arb #(.MAX_DSTREAK(4)) dut4 (.CLK(clk), .RESn(rst_n), .CE(ce), .bus(bus4));
  v810_bus_arb #(.MAX_DSTREAK(0)) dut0 (.CLK(clk), .RESn(rst_n), .CE(ce), .bus(bus0));

  assign bus4.IA = ia;   assign bus4.IREQ = ireq;
  assign bus4.DA = da;   assign bus4.DD_O = dd_o;
  assign bus4.DBE = dbe; assign bus4.DWR = dwr;  assign bus4.DREQ = dreq;
  assign bus0.IA = ia;   assign bus0.IREQ = ireq;
  assign bus0.DA = da;   assign bus0.DD_O = dd_o;
  assign bus0.DBE = dbe; assign bus0.DWR = dwr;  assign bus0.DREQ = dreq;

  // Memory: acknowledges after 'waits' stalled CE cycles; read data is a function of address.
  assign bus4.MACK = ce && bus4.MREQ && (wc4 == waits);
  assign bus0.MACK = ce && bus0.MREQ && (wc0 == waits);
  assign bus4.MD_I = bus4.MA ^ RD_XOR;
  assign bus0.MD_I = bus0.MA ^ RD_XOR;

  always_ff @(posedge clk) begin
    if (!bus4.MREQ || bus4.MACK) wc4 <= 0;
    else if (ce)                 wc4 <= wc4 + 1;
    if (!bus0.MREQ || bus0.MACK) wc0 <= 0;
    else if (ce)                 wc0 <= wc0 + 1;
  end

  logic [1:0]  o_gnt;
  logic        o_mreq, o_iack, o_dack, o_mwr;
  logic [31:0] o_ma, o_md_o, o_id, o_dd_i;
  logic [3:0]  o_mbe;

  assign o_gnt  = use0 ? bus0.GNT  : bus4.GNT;
  assign o_mreq = use0 ? bus0.MREQ : bus4.MREQ;
  assign o_iack = use0 ? bus0.IACK : bus4.IACK;
  assign o_dack = use0 ? bus0.DACK : bus4.DACK;
  assign o_mwr  = use0 ? bus0.MWR  : bus4.MWR;
  assign o_ma   = use0 ? bus0.MA   : bus4.MA;
  assign o_md_o = use0 ? bus0.MD_O : bus4.MD_O;
  assign o_id   = use0 ? bus0.ID   : bus4.ID;
  assign o_dd_i = use0 ? bus0.DD_I : bus4.DD_I;
  assign o_mbe  = use0 ? bus0.MBE  : bus4.MBE;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
    end
  endtask

  task automatic push_exp(input logic [1:0] port, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input logic wr);
    acc_t a;
    a.port = port; a.addr = addr; a.wdata = wdata; a.be = be; a.wr = wr;
    exp_q.push_back(a);
  endtask

  task automatic push_data(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic wr);
    acc_t a;
    a.port = GNT_D; a.addr = addr; a.wdata = wdata; a.be = be; a.wr = wr;
    dq.push_back(a);
  endtask

  task automatic drive();
    ireq = (fq.size() != 0);
    ia   = ireq ? fq[0] : 32'h0;
    dreq = (dq.size() != 0);
    if (dreq) begin
      da = dq[0].addr; dd_o = dq[0].wdata; dbe = dq[0].be; dwr = dq[0].wr;
    end else begin
      da = 32'h0; dd_o = 32'h0; dbe = 4'h0; dwr = 1'b0;
    end
  endtask

  // Owner and address must match the head of the scoreboard whenever the bus is requested.
  task automatic observe();
    acc_t e;
    if (o_mreq && (exp_q.size() != 0)) begin
      check_eq("gnt_owner", 32'(o_gnt), 32'(exp_q[0].port));
      check_eq("ma_owner", o_ma, exp_q[0].addr);
    end
    if (o_iack || o_dack) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_ack", 32'({o_dack, o_iack}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("ack_port", 32'({o_dack, o_iack}), 32'(e.port));
        if (o_iack) begin
          check_eq("id", o_id, e.addr ^ RD_XOR);
          check_eq("i_mbe", 32'(o_mbe), 32'hF);
          check_eq("i_mwr", 32'(o_mwr), 32'd0);
          if (fq.size() != 0) void'(fq.pop_front());
        end else begin
          check_eq("d_mbe", 32'(o_mbe), 32'(e.be));
          check_eq("d_mwr", 32'(o_mwr), 32'(e.wr));
          if (e.wr) check_eq("md_o", o_md_o, e.wdata);
          else      check_eq("dd_i", o_dd_i, e.addr ^ RD_XOR);
          if (dq.size() != 0) void'(dq.pop_front());
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input int budget, output int cyc);
    cyc = 0;
    while ((exp_q.size() != 0) && (cyc < budget)) begin
      step();
      cyc++;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0; ce = 1'b1; use0 = 1'b0;
    fq.push_back(32'h0000_0100);
    drive();
    @(posedge clk); #1;

    // Outputs forced low under reset even with a fetch request present.
    @(negedge clk);
    check_eq("rst_gnt", 32'(o_gnt), 32'(GNT_NONE));
    check_eq("rst_mreq", 32'(o_mreq), 32'd0);
    check_eq("rst_ma", o_ma, 32'd0);
    check_eq("rst_iack", 32'(o_iack), 32'd0);
    @(posedge clk); #1;
    fq.delete();
    drive();
    rst_n = 1'b1;
    step();

    // Zero-wait fetch stream: one completion per cycle.
    waits = 0;
    for (int i = 0; i < 8; i++) begin
      fq.push_back(32'h0000_1000 + 32'(4 * i));
      push_exp(GNT_I, 32'h0000_1000 + 32'(4 * i), 32'h0, 4'hF, 1'b0);
    end
    drive();
    drain(20, cyc);
    check_eq("t1_cycles", 32'(cyc), 32'd8);

    // Both ports busy, one-wait memory: four data wins, then the fetch.
    waits = 1;
    fq.push_back(32'h0000_2000);
    fq.push_back(32'h0000_2004);
    for (int i = 0; i < 8; i++) push_data(32'h0000_3000 + 32'(4 * i), 32'h0, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) push_exp(GNT_D, 32'h0000_3000 + 32'(4 * i), 32'h0, 4'hF, 1'b0);
    push_exp(GNT_I, 32'h0000_2000, 32'h0, 4'hF, 1'b0);
    for (int i = 4; i < 8; i++) push_exp(GNT_D, 32'h0000_3000 + 32'(4 * i), 32'h0, 4'hF, 1'b0);
    push_exp(GNT_I, 32'h0000_2004, 32'h0, 4'hF, 1'b0);
    drive();
    drain(40, cyc);
    check_eq("t2_cycles", 32'(cyc), 32'd20);
    step();

    // Stores ahead of a pending fetch.
    waits = 0;
    fq.push_back(32'h0000_4000);
    push_data(32'h0000_0070, 32'h0000_0009, 4'hF, 1'b1);
    push_data(32'h0000_0074, 32'h0000_0055, 4'h3, 1'b1);
    push_exp(GNT_D, 32'h0000_0070, 32'h0000_0009, 4'hF, 1'b1);
    push_exp(GNT_D, 32'h0000_0074, 32'h0000_0055, 4'h3, 1'b1);
    push_exp(GNT_I, 32'h0000_4000, 32'h0, 4'hF, 1'b0);
    drive();
    drain(10, cyc);
    check_eq("t3_cycles", 32'(cyc), 32'd3);
    step();

    // Fetch lock holds against a data request arriving in the first wait cycle.
    waits = 3;
    fq.push_back(32'h0000_5000);
    push_exp(GNT_I, 32'h0000_5000, 32'h0, 4'hF, 1'b0);
    drive();
    step();
    push_data(32'h0000_6000, 32'h0, 4'hF, 1'b0);
    push_exp(GNT_D, 32'h0000_6000, 32'h0, 4'hF, 1'b0);
    drive();
    drain(20, cyc);
    check_eq("t4_cycles", 32'(cyc), 32'd7);
    step();

    // CE low freezes a lock mid-access.
    waits = 2;
    fq.push_back(32'h0000_A000);
    push_exp(GNT_I, 32'h0000_A000, 32'h0, 4'hF, 1'b0);
    drive();
    step();
    ce = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_eq("ce_no_ack", 32'(exp_q.size()), 32'd1);
    ce = 1'b1;
    drain(10, cyc);
    check_eq("ce_cycles", 32'(cyc), 32'd2);
    step();

    // Reset inside LOCK_D drops the lock; a fetch is granted right after release.
    waits = 3;
    push_data(32'h0000_0080, 32'h0000_00AA, 4'hF, 1'b1);
    push_exp(GNT_D, 32'h0000_0080, 32'h0000_00AA, 4'hF, 1'b1);
    drive();
    step();
    step();
    rst_n = 1'b0;
    dq.delete();
    exp_q.delete();
    fq.push_back(32'h0000_0090);
    drive();
    @(negedge clk);
    check_eq("rl_mreq", 32'(o_mreq), 32'd0);
    check_eq("rl_gnt", 32'(o_gnt), 32'(GNT_NONE));
    check_eq("rl_dack", 32'(o_dack), 32'd0);
    check_eq("rl_ma", o_ma, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_exp(GNT_I, 32'h0000_0090, 32'h0, 4'hF, 1'b0);
    drain(10, cyc);
    check_eq("rl_cycles", 32'(cyc), 32'd4);
    step();

    // Strict data priority: fetch only after the data stream ends.
    pulse_reset();
    use0 = 1'b1;
    waits = 0;
    fq.push_back(32'h0000_7000);
    for (int i = 0; i < 6; i++) begin
      push_data(32'h0000_8000 + 32'(4 * i), 32'h0, 4'hF, 1'b0);
      push_exp(GNT_D, 32'h0000_8000 + 32'(4 * i), 32'h0, 4'hF, 1'b0);
    end
    push_exp(GNT_I, 32'h0000_7000, 32'h0, 4'hF, 1'b0);
    drive();
    drain(20, cyc);
    check_eq("s0_w0_cycles", 32'(cyc), 32'd7);
    step();

    waits = 1;
    fq.push_back(32'h0000_7100);
    for (int i = 0; i < 3; i++) begin
      push_data(32'h0000_9000 + 32'(4 * i), 32'h0, 4'hF, 1'b0);
      push_exp(GNT_D, 32'h0000_9000 + 32'(4 * i), 32'h0, 4'hF, 1'b0);
    end
    push_exp(GNT_I, 32'h0000_7100, 32'h0, 4'hF, 1'b0);
    drive();
    drain(20, cyc);
    check_eq("s0_w1_cycles", 32'(cyc), 32'd8);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
